adc_sample_scheduler: RTL and testbench

//  Shares one serial ADC converter between NUM_CH requesters, each on its own analog mux input.

---
 rtl/adc_sample_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_adc_sample_scheduler.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_scheduler.sv
// Round-robin scheduler sharing one serial ADC between NUM_CH requesters.
// Each grant drives the analog mux, waits for it to settle, starts a
// conversion, waits for done (or timeout) and hands the result back.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no conversion in flight; arbitrate pending requests
// SETTLE  | mux_sel driven, counting down the analog settling time
// START   | issue one-cycle conv_start, arm the timeout counter
// WAIT    | waiting for conv_done or timeout expiry
// DELIVER | return result to requester if it is still asking
module adc_sample_scheduler #(
    parameter int NUM_CH         = 4,
    parameter int ADC_WIDTH      = 12,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int CH_W          = $clog2(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CH-1:0]    req,
    output logic [NUM_CH-1:0]    ack,
    output logic [ADC_WIDTH-1:0] result,
    output logic [CH_W-1:0]      result_ch,
    output logic                 err,
    output logic [CH_W-1:0]      mux_sel,
    output logic                 conv_start,
    input  logic                 conv_done,
    input  logic [ADC_WIDTH-1:0] conv_data,
    output logic                 busy
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        START   = 3'd2,
        WAIT    = 3'd3,
        DELIVER = 3'd4
    } state_t;

    state_t               state, state_nxt;
    logic [CH_W-1:0]      cur_ch, cur_ch_nxt;
    logic [CH_W-1:0]      rr_ptr, rr_nxt;
    logic [SET_W-1:0]     settle_cnt, settle_nxt;
    logic [TO_W-1:0]      timeout_cnt, timeout_nxt;
    logic [ADC_WIDTH-1:0] data_q, data_nxt;
    logic                 tout_q, tout_nxt;

    logic [NUM_CH-1:0]    ack_nxt;
    logic [ADC_WIDTH-1:0] result_nxt;
    logic [CH_W-1:0]      result_ch_nxt;
    logic                 err_nxt;
    logic [CH_W-1:0]      mux_sel_nxt;
    logic                 conv_start_nxt;
    logic                 busy_nxt;

    logic                 pick_found;
    logic [CH_W-1:0]      pick_ch;
    logic [CH_W-1:0]      cand;

    // Round-robin pick: first asserted request at or after rr_ptr, wrapping
    always_comb begin
        pick_found = 1'b0;
        pick_ch    = rr_ptr;
        cand       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = CH_W'((int'(rr_ptr) + i) % NUM_CH);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_ch    = cand;
            end
        end
    end

    // State register plus all registered outputs and datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cur_ch      <= '0;
            rr_ptr      <= '0;
            settle_cnt  <= '0;
            timeout_cnt <= '0;
            data_q      <= '0;
            tout_q      <= 1'b0;
            ack         <= '0;
            result      <= '0;
            result_ch   <= '0;
            err         <= 1'b0;
            mux_sel     <= '0;
            conv_start  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cur_ch      <= cur_ch_nxt;
            rr_ptr      <= rr_nxt;
            settle_cnt  <= settle_nxt;
            timeout_cnt <= timeout_nxt;
            data_q      <= data_nxt;
            tout_q      <= tout_nxt;
            ack         <= ack_nxt;
            result      <= result_nxt;
            result_ch   <= result_ch_nxt;
            err         <= err_nxt;
            mux_sel     <= mux_sel_nxt;
            conv_start  <= conv_start_nxt;
            busy        <= busy_nxt;
        end
    end

    // Next-state and counter/capture logic
    always_comb begin
        state_nxt   = state;
        cur_ch_nxt  = cur_ch;
        rr_nxt      = rr_ptr;
        settle_nxt  = settle_cnt;
        timeout_nxt = timeout_cnt;
        data_nxt    = data_q;
        tout_nxt    = tout_q;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    cur_ch_nxt = pick_ch;
                    settle_nxt = SET_W'(SETTLE_CYCLES - 1);
                    state_nxt  = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == '0) begin
                    state_nxt = START;
                end else begin
                    settle_nxt = settle_cnt - SET_W'(1);
                end
            end
            START: begin
                timeout_nxt = TO_W'(TIMEOUT_CYCLES - 1);
                state_nxt   = WAIT;
            end
            WAIT: begin
                // A done strobe landing on the last timeout cycle still counts
                if (conv_done) begin
                    data_nxt  = conv_data;
                    tout_nxt  = 1'b0;
                    state_nxt = DELIVER;
                end else if (timeout_cnt == '0) begin
                    data_nxt  = '0;
                    tout_nxt  = 1'b1;
                    state_nxt = DELIVER;
                end else begin
                    timeout_nxt = timeout_cnt - TO_W'(1);
                end
            end
            DELIVER: begin
                rr_nxt    = (cur_ch == CH_W'(NUM_CH - 1)) ? '0 : cur_ch + CH_W'(1);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        mux_sel_nxt    = mux_sel;
        conv_start_nxt = (state == START);
        ack_nxt        = '0;
        result_nxt     = '0;
        result_ch_nxt  = '0;
        err_nxt        = 1'b0;
        busy_nxt       = (state_nxt != IDLE);
        if (state == IDLE && pick_found) begin
            mux_sel_nxt = pick_ch;
        end
        // A requester that withdrew gets nothing; the result is dropped
        if (state == DELIVER && req[cur_ch]) begin
            ack_nxt       = NUM_CH'(1) << cur_ch;
            result_nxt    = data_q;
            result_ch_nxt = cur_ch;
            err_nxt       = tout_q;
        end
    end

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Self-checking bench for adc_sample_scheduler: converter model plus a
// round-robin/latency reference model evaluated with plain arithmetic.
module tb_adc_sample_scheduler;

    localparam int NUM_CH = 4;
    localparam int ADC_WIDTH = 12;
    localparam int S = 16;
    localparam int T = 1024;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  ack;
    logic [11:0] result;
    logic [1:0]  result_ch;
    logic        err;
    logic [1:0]  mux_sel;
    logic        conv_start;
    logic        conv_done;
    logic [11:0] conv_data;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int model_rr = 0;
    int conv_delay = -1;
    logic [11:0] conv_value = 12'h000;

    adc_sample_scheduler #(
        .NUM_CH(NUM_CH), .ADC_WIDTH(ADC_WIDTH),
        .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .result(result),
        .result_ch(result_ch), .err(err), .mux_sel(mux_sel),
        .conv_start(conv_start), .conv_done(conv_done),
        .conv_data(conv_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Converter model: strobe done conv_delay cycles after seeing conv_start
    initial begin
        conv_done = 1'b0;
        conv_data = 12'h000;
        forever begin
            @(negedge clk);
            if (conv_start === 1'b1 && conv_delay >= 0) begin
                repeat (conv_delay) @(negedge clk);
                conv_done = 1'b1;
                conv_data = conv_value;
                @(negedge clk);
                conv_done = 1'b0;
            end
        end
    end

    // Reference arbitration: first requester at or after ptr, wrapping
    function automatic int pick(input logic [3:0] m, input int ptr);
        for (int i = 0; i < 4; i++) begin
            if (m[2'((ptr + i) % 4)]) return (ptr + i) % 4;
        end
        return -1;
    endfunction

    // Expected ack cycle given conv_start cycle and converter delay (-1 = never)
    function automatic int exp_ack_cycle(input int sc, input int d);
        if (d >= 0 && d <= T - 1) return sc + d + 2;
        return sc + T + 1;
    endfunction

    // One request episode; records what the DUT did (no checking here)
    task automatic run_one(input logic [3:0] mask, input int d, input bit drop,
                           input logic [11:0] val, output int k, output int sc,
                           output int ac, output int end_c, output logic [3:0] ack_v,
                           output logic [11:0] res_v, output logic [1:0] ch_v,
                           output logic err_v, output int ack_cnt,
                           output bit mux_stable, output logic [1:0] mux_v);
        conv_delay = d;
        conv_value = val;
        sc = -1; ac = -1; end_c = -1; ack_v = '0; res_v = '0; ch_v = '0;
        err_v = 1'b0; ack_cnt = 0; mux_stable = 1'b1; mux_v = '0;
        req = mask;
        k = cyc + 1;
        for (int n = 0; n < T + 200; n++) begin
            @(negedge clk);
            if (cyc == k) mux_v = mux_sel;
            else if (cyc > k && sc < 0 && mux_sel !== mux_v) mux_stable = 1'b0;
            if (conv_start === 1'b1 && sc < 0) sc = cyc;
            if (drop && cyc == k + 4) req = 4'b0000;
            if (ack !== 4'b0000) begin
                ack_cnt++;
                if (ac < 0) begin
                    ac = cyc; ack_v = ack; res_v = result; ch_v = result_ch; err_v = err;
                end
                req = 4'b0000;
            end
            if (sc >= 0 && busy === 1'b0 && (ac < 0 || cyc > ac)) begin
                end_c = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 4'b0000;
        repeat (3) @(negedge clk);
        checks++;
        if ({ack, result, result_ch, err, mux_sel, conv_start, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ack=%b result=%h ch=%0d err=%b mux=%0d start=%b busy=%b, expected all zero",
                     ack, result, result_ch, err, mux_sel, conv_start, busy);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || conv_start !== 1'b0 || ack !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b start=%b ack=%b, expected 0 0 0000", busy, conv_start, ack);
        end
        model_rr = 0;
    endtask

    task automatic test_back_to_back();
        int k, sc, ac, ex, d, extra;
        logic [11:0] v;
        extra = 0;
        d = $urandom_range(0, 12);
        v = 12'($urandom);
        conv_delay = d;
        conv_value = v;
        req = 4'b1111;
        k = cyc + 1;
        for (int i = 0; i < 5; i++) begin
            ex = pick(4'b1111, model_rr);
            sc = -1;
            for (int n = 0; n < 200 && sc < 0; n++) begin
                @(negedge clk);
                if (ack !== 4'b0000) extra++;
                if (conv_start === 1'b1) sc = cyc;
            end
            checks++;
            if (sc != k + S + 1) begin
                errors++;
                $display("FAIL b2b_start[%0d]: got cycle %0d, expected %0d", i, sc, k + S + 1);
            end
            checks++;
            if (mux_sel !== 2'(ex)) begin
                errors++;
                $display("FAIL b2b_mux[%0d]: got %0d, expected %0d", i, mux_sel, ex);
            end
            ac = -1;
            for (int n = 0; n < T + 10 && ac < 0; n++) begin
                @(negedge clk);
                if (ack !== 4'b0000) ac = cyc;
            end
            checks++;
            if (ac != exp_ack_cycle(sc, d)) begin
                errors++;
                $display("FAIL b2b_ack_cycle[%0d]: got %0d, expected %0d", i, ac, exp_ack_cycle(sc, d));
            end
            checks++;
            if (ack !== 4'(1 << ex) || !$onehot(ack) || result !== v || result_ch !== 2'(ex) || err !== 1'b0) begin
                errors++;
                $display("FAIL b2b_ack[%0d]: got ack=%b result=%h ch=%0d err=%b, expected ack=%b result=%h ch=%0d err=0",
                         i, ack, result, result_ch, err, 4'(1 << ex), v, ex);
            end
            model_rr = (ex + 1) % 4;
            k = ac + 1;
            if (i == 4) begin
                req = 4'b0000;
            end else begin
                d = $urandom_range(0, 12);
                v = 12'($urandom);
                conv_delay = d;
                conv_value = v;
            end
        end
        repeat (3) begin
            @(negedge clk);
            if (ack !== 4'b0000) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL b2b_extra_acks: got %0d, expected 0", extra);
        end
    endtask

    task automatic test_single();
        int k, sc, ac, ec, cnt;
        logic [3:0] av; logic [11:0] rv; logic [1:0] cv, mv; logic ev; bit ms;
        int ex;
        ex = pick(4'b0100, model_rr);
        run_one(4'b0100, 5, 1'b0, 12'hA5C, k, sc, ac, ec, av, rv, cv, ev, cnt, ms, mv);
        checks++;
        if (sc != k + S + 1 || mv !== 2'(ex) || !ms) begin
            errors++;
            $display("FAIL single_settle: got start=%0d mux=%0d stable=%0d, expected start=%0d mux=%0d stable=1",
                     sc, mv, ms, k + S + 1, ex);
        end
        checks++;
        if (ac != sc + 7 || av !== 4'b0100 || rv !== 12'hA5C || cv !== 2'd2 || ev !== 1'b0 || cnt != 1) begin
            errors++;
            $display("FAIL single_ack: got cyc=%0d ack=%b result=%h ch=%0d err=%b n=%0d, expected cyc=%0d ack=0100 result=a5c ch=2 err=0 n=1",
                     ac, av, rv, cv, ev, cnt, sc + 7);
        end
        model_rr = (ex + 1) % 4;
    endtask

    task automatic test_timeout();
        int k, sc, ac, ec, cnt;
        logic [3:0] av; logic [11:0] rv; logic [1:0] cv, mv; logic ev; bit ms;
        logic [11:0] v;
        run_one(4'b0010, -1, 1'b0, 12'hFFF, k, sc, ac, ec, av, rv, cv, ev, cnt, ms, mv);
        checks++;
        if (ac != sc + T + 1 || av !== 4'b0010 || ev !== 1'b1 || rv !== 12'h000 || cv !== 2'd1 || cnt != 1) begin
            errors++;
            $display("FAIL timeout_ack: got cyc=%0d ack=%b err=%b result=%h ch=%0d n=%0d, expected cyc=%0d ack=0010 err=1 result=000 ch=1 n=1",
                     ac, av, ev, rv, cv, cnt, sc + T + 1);
        end
        model_rr = 2;
        v = 12'($urandom);
        run_one(4'b0100, 3, 1'b0, v, k, sc, ac, ec, av, rv, cv, ev, cnt, ms, mv);
        checks++;
        if (ac != sc + 5 || av !== 4'b0100 || ev !== 1'b0 || rv !== v) begin
            errors++;
            $display("FAIL timeout_recover: got cyc=%0d ack=%b err=%b result=%h, expected cyc=%0d ack=0100 err=0 result=%h",
                     ac, av, ev, rv, sc + 5, v);
        end
        model_rr = 3;
    endtask

    task automatic test_drop();
        int k, sc, ac, ec, cnt, ex;
        logic [3:0] av; logic [11:0] rv; logic [1:0] cv, mv; logic ev; bit ms;
        run_one(4'b1000, 6, 1'b1, 12'h123, k, sc, ac, ec, av, rv, cv, ev, cnt, ms, mv);
        checks++;
        if (sc != k + S + 1 || cnt != 0 || ec != sc + 8) begin
            errors++;
            $display("FAIL drop_no_ack: got start=%0d acks=%0d idle_at=%0d, expected start=%0d acks=0 idle_at=%0d",
                     sc, cnt, ec, k + S + 1, sc + 8);
        end
        model_rr = 0;
        ex = pick(4'b1111, model_rr);
        run_one(4'b1111, 2, 1'b0, 12'h456, k, sc, ac, ec, av, rv, cv, ev, cnt, ms, mv);
        checks++;
        if (av !== 4'(1 << ex) || cv !== 2'(ex) || rv !== 12'h456) begin
            errors++;
            $display("FAIL drop_rr_next: got ack=%b ch=%0d result=%h, expected ack=%b ch=%0d result=456",
                     av, cv, rv, 4'(1 << ex), ex);
        end
        model_rr = (ex + 1) % 4;
    endtask

    task automatic test_collision();
        int k, sc, ac, ec, cnt, ex;
        logic [3:0] av; logic [11:0] rv; logic [1:0] cv, mv; logic ev; bit ms;
        logic [11:0] v;
        v = 12'($urandom_range(1, 4095));
        ex = pick(4'b0001, model_rr);
        run_one(4'b0001, T - 1, 1'b0, v, k, sc, ac, ec, av, rv, cv, ev, cnt, ms, mv);
        checks++;
        if (ac != sc + T + 1 || av !== 4'b0001 || ev !== 1'b0 || rv !== v) begin
            errors++;
            $display("FAIL collision: got cyc=%0d ack=%b err=%b result=%h, expected cyc=%0d ack=0001 err=0 result=%h",
                     ac, av, ev, rv, sc + T + 1, v);
        end
        model_rr = (ex + 1) % 4;
    endtask

    task automatic test_random();
        int k, sc, ac, ec, cnt, ex, d, r, ea;
        logic [3:0] av, mask; logic [11:0] rv, v; logic [1:0] cv, mv; logic ev; bit ms, drop, terr;
        for (int it = 0; it < 12; it++) begin
            mask = 4'($urandom_range(1, 15));
            r = $urandom_range(0, 9);
            d = (r == 0) ? -1 : (r == 1) ? T - 1 : $urandom_range(0, 30);
            drop = ($urandom_range(0, 4) == 0);
            v = 12'($urandom);
            ex = pick(mask, model_rr);
            run_one(mask, d, drop, v, k, sc, ac, ec, av, rv, cv, ev, cnt, ms, mv);
            ea = exp_ack_cycle(sc, d);
            terr = !(d >= 0 && d <= T - 1);
            checks++;
            if (sc != k + S + 1 || mv !== 2'(ex) || !ms) begin
                errors++;
                $display("FAIL rand_grant[%0d]: got start=%0d mux=%0d stable=%0d, expected start=%0d mux=%0d stable=1",
                         it, sc, mv, ms, k + S + 1, ex);
            end
            if (drop) begin
                checks++;
                if (cnt != 0 || ec != ea) begin
                    errors++;
                    $display("FAIL rand_drop[%0d]: got acks=%0d idle_at=%0d, expected acks=0 idle_at=%0d", it, cnt, ec, ea);
                end
            end else begin
                checks++;
                if (ac != ea || av !== 4'(1 << ex) || cv !== 2'(ex) || ev !== terr ||
                    rv !== (terr ? 12'h000 : v) || cnt != 1) begin
                    errors++;
                    $display("FAIL rand_ack[%0d]: got cyc=%0d ack=%b ch=%0d err=%b result=%h n=%0d, expected cyc=%0d ack=%b ch=%0d err=%b result=%h n=1",
                             it, ac, av, cv, ev, rv, cnt, ea, 4'(1 << ex), ex, terr, terr ? 12'h000 : v);
                end
            end
            model_rr = (ex + 1) % 4;
        end
    endtask

    task automatic test_reset_mid();
        int sc, bad_ack, bad_busy, bad_start, bad_mux;
        bad_ack = 0; bad_busy = 0; bad_start = 0; bad_mux = 0;
        conv_delay = 20;
        conv_value = 12'h7E7;
        req = 4'b0100;
        sc = -1;
        for (int n = 0; n < 200 && sc < 0; n++) begin
            @(negedge clk);
            if (conv_start === 1'b1) sc = cyc;
        end
        checks++;
        if (sc < 0 || mux_sel !== 2'd2) begin
            errors++;
            $display("FAIL rstmid_start: got start=%0d mux=%0d, expected a start with mux=2", sc, mux_sel);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ack, result, result_ch, err, mux_sel, conv_start, busy} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: got ack=%b result=%h ch=%0d err=%b mux=%0d start=%b busy=%b, expected all zero",
                     ack, result, result_ch, err, mux_sel, conv_start, busy);
        end
        @(negedge clk);
        req = 4'b0000;
        rst_n = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (ack !== 4'b0000 || err !== 1'b0) bad_ack++;
            if (busy !== 1'b0) bad_busy++;
            if (conv_start !== 1'b0) bad_start++;
            if (mux_sel !== 2'd0) bad_mux++;
        end
        checks++;
        if (bad_ack != 0 || bad_busy != 0 || bad_start != 0 || bad_mux != 0) begin
            errors++;
            $display("FAIL rstmid_after: got ack_cycles=%0d busy_cycles=%0d start_cycles=%0d mux_cycles=%0d, expected all 0",
                     bad_ack, bad_busy, bad_start, bad_mux);
        end
        model_rr = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        req = 4'b0000;
        test_reset();
        test_back_to_back();
        test_single();
        test_timeout();
        test_drop();
        test_collision();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
